// File: rtl/loop_div_pkg.sv
// rtl/loop_div_pkg.sv - shared types, widths and match helper for the loop divider meter
package loop_div_pkg;

  localparam int CNT_W  = 7;
  localparam int DIVN_W = 6;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EDGE,
    ST_MEASURE
  } state_t;

  // A period is good when its length equals div_n and its high time is within half a cycle of 50 %.
  function automatic logic period_match(input logic [CNT_W-1:0]  period,
                                        input logic [CNT_W-1:0]  high,
                                        input logic [DIVN_W-1:0] div_n);
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] lo;
    logic [CNT_W-1:0] hi;
    n  = CNT_W'(div_n);
    lo = n >> 1;
    hi = (n + CNT_W'(1)) >> 1;
    return (period == n) && ((high == lo) || (high == hi));
  endfunction

endpackage

// File: rtl/loop_div_sync.sv
// rtl/loop_div_sync.sv - two-flop synchronizer plus edge flop for the divided clock
module loop_div_sync (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic level,
  output logic level_q,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= div_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign level   = sync2;
  assign level_q = sync3;
  assign rise    = sync2 & ~sync3;

endmodule

// File: rtl/loop_div_meter.sv
// rtl/loop_div_meter.sv - measures period and high time of a divided clock and reports lock
module loop_div_meter
  import loop_div_pkg::*;
#(
  parameter int LOCK_N  = 4,
  parameter int TIMEOUT = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIVN_W-1:0] div_n,
  input  logic              div_in,
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  high_o,
  output logic              meas_valid,
  output logic              lock,
  output logic              err,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_N);

  state_t            state;
  state_t            state_nxt;
  logic [DIVN_W-1:0] div_n_q;
  logic [CNT_W-1:0]  period_cnt;
  logic [CNT_W-1:0]  high_cnt;
  logic [CNT_W-1:0]  good_cnt;
  logic [CNT_W-1:0]  good_nxt;
  logic              level;
  logic              level_q;
  logic              rise;
  logic              div_chg;
  logic              match;
  logic              meas_evt;
  logic              to_evt;
  logic              lock_nxt;

  loop_div_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .div_in  (div_in),
    .level   (level),
    .level_q (level_q),
    .rise    (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A div_n change overrides every other event in the same cycle.
  always_comb begin
    state_nxt = state;
    if (div_chg) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (div_n_q >= DIVN_W'(2)) state_nxt = ST_WAIT_EDGE;
        ST_WAIT_EDGE: if (rise) state_nxt = ST_MEASURE;
        ST_MEASURE:   if (to_evt) state_nxt = ST_WAIT_EDGE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    div_chg  = (div_n != div_n_q);
    match    = period_match(period_cnt, high_cnt, div_n_q);
    meas_evt = 1'b0;
    to_evt   = 1'b0;
    if (!div_chg && (state == ST_MEASURE)) begin
      if (rise) begin
        meas_evt = 1'b1;
      end else if (period_cnt >= TO_CNT) begin
        to_evt = 1'b1;
      end
    end

    good_nxt = good_cnt;
    if (div_chg || to_evt || (meas_evt && !match)) begin
      good_nxt = '0;
    end else if (meas_evt && (good_cnt < LOCK_CNT)) begin
      good_nxt = good_cnt + CNT_W'(1);
    end

    lock_nxt = lock;
    if (div_chg || to_evt) begin
      lock_nxt = 1'b0;
    end else if (meas_evt) begin
      lock_nxt = match && (good_nxt == LOCK_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_n_q    <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      good_cnt   <= '0;
      period_o   <= '0;
      high_o     <= '0;
      meas_valid <= 1'b0;
      lock       <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      div_n_q    <= div_n;
      good_cnt   <= good_nxt;
      lock       <= lock_nxt;
      meas_valid <= meas_evt;
      err        <= meas_evt & ~match;
      timeout    <= to_evt;
      if (meas_evt) begin
        period_o <= period_cnt;
        high_o   <= high_cnt;
      end

      if (div_chg || (state == ST_IDLE)) begin
        period_cnt <= '0;
        high_cnt   <= '0;
      end else if (rise) begin
        period_cnt <= CNT_W'(1);
        high_cnt   <= CNT_W'(1);
      end else begin
        if (period_cnt != CNT_MAX) period_cnt <= period_cnt + CNT_W'(1);
        // The rise cycle is already counted by the load, so only cycles still high after it add.
        if (level && level_q && (high_cnt != CNT_MAX)) high_cnt <= high_cnt + CNT_W'(1);
      end
    end
  end

endmodule
